soc_bus_arbiter: RTL and testbench

Two-master arbiter that shares the SoC memory/peripheral bus (RAM plus the chip-select-decoded peripherals) between the FemtoRV32 CPU and a secondary bus master such as a DMA or debug loader. It captures CPU strobes, drives real `mem_rbusy`/`mem_wbusy` back to the CPU instead of tying them low, and issues one slave access at a time with a fixed, parameterised response latency. It sits between the CPU and the existing address-decoder/read-mux fabric.

---
 rtl/soc_bus_arbiter_if.sv | 53 +++++
 rtl/soc_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_soc_bus_arbiter.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_bus_arbiter_if.sv
// Bus bundle shared by the two masters, the arbiter and the slave fabric.
//   master modport : environment view (CPU and m1 drive requests; the fabric drives s_rdata)
//   slave  modport : arbiter view (serves master requests, drives the slave strobes)
// Signals:
//   m0_* : FemtoRV32 CPU strobe interface (addr, wdata, wmask, rstrb / rdata, rbusy, wbusy)
//   m1_* : secondary master level handshake (req, we, addr, wdata, wmask / gnt, done, rdata)
//   s_*  : single slave access (addr, wdata, wmask, rstrb / rdata)
interface soc_bus_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [MASK_W-1:0] m0_wmask;
    logic              m0_rstrb;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rbusy;
    logic              m0_wbusy;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [MASK_W-1:0] m1_wmask;
    logic              m1_gnt;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [MASK_W-1:0] s_wmask;
    logic              s_rstrb;
    logic [DATA_W-1:0] s_rdata;

    modport master (
        output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
        input  m0_rdata, m0_rbusy, m0_wbusy,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
        input  m1_gnt, m1_done, m1_rdata,
        input  s_addr, s_wdata, s_wmask, s_rstrb,
        output s_rdata
    );

    modport slave (
        input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
        output m0_rdata, m0_rbusy, m0_wbusy,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wmask,
        output m1_gnt, m1_done, m1_rdata,
        output s_addr, s_wdata, s_wmask, s_rstrb,
        input  s_rdata
    );
endinterface

// File: rtl/soc_bus_arbiter.sv
// Two-master arbiter for the SoC memory/peripheral bus.
// The CPU (m0) strobes are captured into a pending request and answered with
// real rbusy/wbusy stalls; the secondary master (m1) uses a level req/done
// handshake. One slave access is issued at a time: a one-cycle ISSUE strobe
// followed by WAIT_CYCLES (1..15) cycles before s_rdata is sampled.
// Ties are broken round-robin; m0 wins the first tie after reset.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : soc_bus_arbiter_if.slave (m0_*, m1_*, s_* signals), all outputs registered
module soc_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    soc_bus_arbiter_if.slave     bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;           // 0 = m0, 1 = m1
    logic                last_owner_q, last_owner_d;
    logic                cur_we_q, cur_we_d;         // kind of the access in flight
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                m0_pend_q, m0_pend_d;
    logic                m0_we_q, m0_we_d;
    logic [ADDR_W-1:0]   m0_addr_q, m0_addr_d;
    logic [DATA_W-1:0]   m0_wdata_q, m0_wdata_d;
    logic [MASK_W-1:0]   m0_wmask_q, m0_wmask_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic                m0_rbusy_q, m0_rbusy_d;
    logic                m0_wbusy_q, m0_wbusy_d;

    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                m1_done_q, m1_done_d;
    logic                m1_gnt_q, m1_gnt_d;

    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [MASK_W-1:0]   s_wmask_q, s_wmask_d;
    logic                s_rstrb_q, s_rstrb_d;

    logic                m1_cand;
    logic                grant_m1;

    // Next-state logic: CPU capture, arbitration and access sequencing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cur_we_d     = cur_we_q;
        cnt_d        = cnt_q;
        m0_pend_d    = m0_pend_q;
        m0_we_d      = m0_we_q;
        m0_addr_d    = m0_addr_q;
        m0_wdata_d   = m0_wdata_q;
        m0_wmask_d   = m0_wmask_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m1_done_d    = 1'b0;
        m1_gnt_d     = m1_gnt_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wmask_d    = '0;
        s_rstrb_d    = 1'b0;
        grant_m1     = 1'b0;
        // m1 keeps req high through its done pulse; that cycle must not regrant.
        m1_cand      = bus.m1_req & ~m1_done_q;

        // CPU strobe capture; a read strobe wins over a simultaneous write.
        if (!m0_pend_q && (bus.m0_rstrb || (|bus.m0_wmask))) begin
            m0_pend_d  = 1'b1;
            m0_we_d    = ~bus.m0_rstrb;
            m0_addr_d  = bus.m0_addr;
            m0_wdata_d = bus.m0_wdata;
            m0_wmask_d = bus.m0_rstrb ? MASK_W'(0) : bus.m0_wmask;
        end

        case (state_q)
            S_IDLE: begin
                if (m0_pend_q || m1_cand) begin
                    grant_m1 = m1_cand && (!m0_pend_q || !last_owner_q);
                    owner_d  = grant_m1;
                    m1_gnt_d = grant_m1;
                    state_d  = S_ISSUE;
                    if (grant_m1) begin
                        cur_we_d  = bus.m1_we;
                        s_addr_d  = bus.m1_addr;
                        s_wdata_d = bus.m1_wdata;
                        s_wmask_d = bus.m1_we ? bus.m1_wmask : MASK_W'(0);
                        s_rstrb_d = ~bus.m1_we;
                    end else begin
                        cur_we_d  = m0_we_q;
                        s_addr_d  = m0_addr_q;
                        s_wdata_d = m0_wdata_q;
                        s_wmask_d = m0_we_q ? m0_wmask_q : MASK_W'(0);
                        s_rstrb_d = ~m0_we_q;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (!cur_we_q) begin
                        if (owner_q) m1_rdata_d = bus.s_rdata;
                        else         m0_rdata_d = bus.s_rdata;
                    end
                    if (owner_q) m1_done_d = 1'b1;
                    else         m0_pend_d = 1'b0;
                    last_owner_d = owner_q;
                    m1_gnt_d     = 1'b0;
                    s_addr_d     = '0;
                    s_wdata_d    = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        m0_rbusy_d = m0_pend_d & ~m0_we_d;
        m0_wbusy_d = m0_pend_d & m0_we_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cur_we_q     <= 1'b0;
            cnt_q        <= '0;
            m0_pend_q    <= 1'b0;
            m0_we_q      <= 1'b0;
            m0_addr_q    <= '0;
            m0_wdata_q   <= '0;
            m0_wmask_q   <= '0;
            m0_rdata_q   <= '0;
            m0_rbusy_q   <= 1'b0;
            m0_wbusy_q   <= 1'b0;
            m1_rdata_q   <= '0;
            m1_done_q    <= 1'b0;
            m1_gnt_q     <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_wmask_q    <= '0;
            s_rstrb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cur_we_q     <= cur_we_d;
            cnt_q        <= cnt_d;
            m0_pend_q    <= m0_pend_d;
            m0_we_q      <= m0_we_d;
            m0_addr_q    <= m0_addr_d;
            m0_wdata_q   <= m0_wdata_d;
            m0_wmask_q   <= m0_wmask_d;
            m0_rdata_q   <= m0_rdata_d;
            m0_rbusy_q   <= m0_rbusy_d;
            m0_wbusy_q   <= m0_wbusy_d;
            m1_rdata_q   <= m1_rdata_d;
            m1_done_q    <= m1_done_d;
            m1_gnt_q     <= m1_gnt_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wmask_q    <= s_wmask_d;
            s_rstrb_q    <= s_rstrb_d;
        end
    end

    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m0_rbusy = m0_rbusy_q;
    assign bus.m0_wbusy = m0_wbusy_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.m1_gnt   = m1_gnt_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.s_wmask  = s_wmask_q;
    assign bus.s_rstrb  = s_rstrb_q;
endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Testbench for soc_bus_arbiter: directed scenarios plus randomized traffic
// from both masters checked against a transaction-level model (ROM-like slave,
// expected write queues, latency bounds).
module tb_soc_bus_arbiter;
    localparam int unsigned W = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    soc_bus_arbiter_if bus ();

    soc_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        use_rom;
    logic [31:0] s_val;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    bit  d0, d1;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    assign bus.s_rdata = use_rom ? rom(bus.s_addr) : s_val;

    function automatic logic [136:0] outs();
        return {bus.m0_rdata, bus.m0_rbusy, bus.m0_wbusy, bus.m1_gnt, bus.m1_done,
                bus.m1_rdata, bus.s_addr, bus.s_wdata, bus.s_wmask, bus.s_rstrb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_addr  = '0;
        bus.m0_wdata = '0;
        bus.m0_wmask = '0;
        bus.m0_rstrb = 1'b0;
        bus.m1_req   = 1'b0;
        bus.m1_we    = 1'b0;
        bus.m1_addr  = '0;
        bus.m1_wdata = '0;
        bus.m1_wmask = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        use_rom = 1'b0;
        s_val   = 32'h0;
        rst     = 1'b1;
        tick();
        total++;
        if (outs() !== 137'd0) begin
            bad++; $display("FAIL reset_outs got=%h exp=0", outs());
        end
        bus.m0_rstrb = 1'b1;
        bus.m1_req   = 1'b1;
        tick();
        total++;
        if (outs() !== 137'd0) begin
            bad++; $display("FAIL reset_held_outs got=%h exp=0", outs());
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_m0_read();
        logic exp;
        do_reset();
        use_rom = 1'b0;
        s_val   = 32'hDEAD_BEEF;
        bus.m0_addr  = 32'h0000_0100;
        bus.m0_rstrb = 1'b1;
        for (int c = 1; c <= 3 + W; c++) begin
            tick();
            if (c == 1) bus.m0_rstrb = 1'b0;
            exp = (c <= 2 + W);
            total++;
            if (bus.m0_rbusy !== exp) begin
                bad++; $display("FAIL m0_read_rbusy c=%0d got=%b exp=%b", c, bus.m0_rbusy, exp);
            end
            exp = (c == 2);
            total++;
            if (bus.s_rstrb !== exp) begin
                bad++; $display("FAIL m0_read_rstrb c=%0d got=%b exp=%b", c, bus.s_rstrb, exp);
            end
            if (c == 2) begin
                total++;
                if (bus.s_addr !== 32'h100) begin
                    bad++; $display("FAIL m0_read_addr got=%h exp=00000100", bus.s_addr);
                end
            end
            if (c == 3 + W) begin
                total++;
                if (bus.m0_rdata !== 32'hDEAD_BEEF) begin
                    bad++; $display("FAIL m0_read_data got=%h exp=deadbeef", bus.m0_rdata);
                end
                total++;
                if (bus.s_addr !== 32'h0) begin
                    bad++; $display("FAIL m0_read_idle_addr got=%h exp=0", bus.s_addr);
                end
            end
        end
    endtask

    task automatic test_m0_write();
        logic exp;
        bus.m0_addr  = 32'h0040_0008;
        bus.m0_wdata = 32'h41;
        bus.m0_wmask = 4'b0001;
        for (int c = 1; c <= 3 + W; c++) begin
            tick();
            if (c == 1) bus.m0_wmask = 4'b0000;
            exp = (c <= 2 + W);
            total++;
            if (bus.m0_wbusy !== exp || bus.m0_rbusy !== 1'b0) begin
                bad++; $display("FAIL m0_write_busy c=%0d got=%b/%b exp=%b/0", c, bus.m0_wbusy, bus.m0_rbusy, exp);
            end
            total++;
            if (bus.s_wmask !== ((c == 2) ? 4'b0001 : 4'b0000) || bus.s_rstrb !== 1'b0) begin
                bad++; $display("FAIL m0_write_strobe c=%0d got=%b/%b", c, bus.s_wmask, bus.s_rstrb);
            end
            if (c == 2) begin
                total++;
                if (bus.s_addr !== 32'h0040_0008 || bus.s_wdata !== 32'h41) begin
                    bad++; $display("FAIL m0_write_addr got=%h/%h exp=00400008/00000041", bus.s_addr, bus.s_wdata);
                end
            end
        end
        total++;
        if (bus.m0_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL m0_write_rdata_kept got=%h exp=deadbeef", bus.m0_rdata);
        end
    endtask

    task automatic test_m1_read();
        logic exp;
        s_val        = 32'h1234;
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b0;
        bus.m1_addr  = 32'h200;
        bus.m1_wmask = 4'hF;
        for (int c = 1; c <= 3 + W; c++) begin
            tick();
            exp = (c <= 1 + W);
            total++;
            if (bus.m1_gnt !== exp) begin
                bad++; $display("FAIL m1_read_gnt c=%0d got=%b exp=%b", c, bus.m1_gnt, exp);
            end
            exp = (c == 2 + W);
            total++;
            if (bus.m1_done !== exp) begin
                bad++; $display("FAIL m1_read_done c=%0d got=%b exp=%b", c, bus.m1_done, exp);
            end
            total++;
            if (bus.s_rstrb !== (c == 1) || bus.s_wmask !== 4'h0) begin
                bad++; $display("FAIL m1_read_strobe c=%0d got=%b/%b", c, bus.s_rstrb, bus.s_wmask);
            end
            if (c == 2 + W) begin
                total++;
                if (bus.m1_rdata !== 32'h1234) begin
                    bad++; $display("FAIL m1_read_data got=%h exp=00001234", bus.m1_rdata);
                end
                bus.m1_req = 1'b0;
            end
        end
    endtask

    task automatic test_boundaries();
        // read and write strobes together: read wins
        s_val        = 32'h77;
        bus.m0_addr  = 32'h600;
        bus.m0_rstrb = 1'b1;
        bus.m0_wmask = 4'hF;
        for (int c = 1; c <= 3 + W; c++) begin
            tick();
            if (c == 1) begin
                bus.m0_rstrb = 1'b0;
                bus.m0_wmask = 4'h0;
                total++;
                if (bus.m0_rbusy !== 1'b1 || bus.m0_wbusy !== 1'b0) begin
                    bad++; $display("FAIL both_strobe_busy got=%b/%b exp=1/0", bus.m0_rbusy, bus.m0_wbusy);
                end
            end
            if (c == 2) begin
                total++;
                if (bus.s_rstrb !== 1'b1 || bus.s_wmask !== 4'h0) begin
                    bad++; $display("FAIL both_strobe_slave got=%b/%b exp=1/0", bus.s_rstrb, bus.s_wmask);
                end
            end
        end
        total++;
        if (bus.m0_rdata !== 32'h77 || bus.m0_rbusy !== 1'b0) begin
            bad++; $display("FAIL both_strobe_data got=%h/%b exp=00000077/0", bus.m0_rdata, bus.m0_rbusy);
        end
        // m1 write with empty mask still completes
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b1;
        bus.m1_addr  = 32'h700;
        bus.m1_wmask = 4'h0;
        for (int c = 1; c <= 2 + W; c++) begin
            tick();
            total++;
            if (bus.s_wmask !== 4'h0 || bus.s_rstrb !== 1'b0 || bus.m1_done !== (c == 2 + W)) begin
                bad++; $display("FAIL m1_mask0 c=%0d got=%b/%b/%b", c, bus.s_wmask, bus.s_rstrb, bus.m1_done);
            end
        end
        bus.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        use_rom = 1'b1;
        bus.m0_addr  = 32'h300;
        bus.m0_rstrb = 1'b1;
        bus.m1_we    = 1'b0;
        bus.m1_addr  = 32'h400;
        for (int c = 1; c <= 5 + 2 * W; c++) begin
            tick();
            if (c == 1) begin
                bus.m0_rstrb = 1'b0;
                bus.m1_req   = 1'b1;  // both candidates present together in IDLE
            end
            total++;
            if (bus.s_rstrb !== (c == 2 || c == 4 + W)) begin
                bad++; $display("FAIL contention_rstrb c=%0d got=%b", c, bus.s_rstrb);
            end
            if (c == 2 || c == 4 + W) begin
                total++;
                if (bus.s_addr !== ((c == 2) ? 32'h300 : 32'h400) || bus.m1_gnt !== (c != 2)) begin
                    bad++; $display("FAIL contention_owner c=%0d got=%h/%b", c, bus.s_addr, bus.m1_gnt);
                end
            end
            if (c == 3 + W) begin
                total++;
                if (bus.m0_rdata !== rom(32'h300) || bus.m0_rbusy !== 1'b0) begin
                    bad++; $display("FAIL contention_m0_data got=%h exp=%h", bus.m0_rdata, rom(32'h300));
                end
            end
            if (c == 5 + 2 * W) begin
                total++;
                if (bus.m1_done !== 1'b1 || bus.m1_rdata !== rom(32'h400)) begin
                    bad++; $display("FAIL contention_m1_data got=%b/%h exp=1/%h", bus.m1_done, bus.m1_rdata, rom(32'h400));
                end
                bus.m1_req = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        int seen[$];
        int exp_order[5] = '{1, 0, 1, 0, 1};
        int n;
        // lone m0 access makes m0 the last owner
        bus.m0_addr  = 32'h10;
        bus.m0_rstrb = 1'b1;
        tick();
        bus.m0_rstrb = 1'b0;
        n = 0;
        while (bus.m0_rbusy && n < 50) begin tick(); n++; end
        // tie in IDLE, then both keep requesting
        bus.m0_addr  = 32'h20;
        bus.m0_rstrb = 1'b1;
        bus.m1_addr  = 32'h30;
        bus.m1_we    = 1'b0;
        n = 0;
        while (seen.size() < 5 && n < 100) begin
            tick();
            n++;
            if (n == 1) bus.m1_req = 1'b1;
            if (bus.s_rstrb) seen.push_back(int'(bus.m1_gnt));
            if (bus.m0_rstrb) bus.m0_rstrb = 1'b0;
            else if (!bus.m0_rbusy) bus.m0_rstrb = 1'b1;
        end
        total++;
        if (seen.size() != 5) begin
            bad++; $display("FAIL rr_timeout got=%0d grants exp=5", seen.size());
        end
        for (int i = 0; i < seen.size(); i++) begin
            total++;
            if (seen[i] != exp_order[i]) begin
                bad++; $display("FAIL rr_order idx=%0d got=m%0d exp=m%0d", i, seen[i], exp_order[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_m1_hold();
        use_rom      = 1'b0;
        s_val        = 32'h55;
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b0;
        bus.m1_addr  = 32'h800;
        for (int c = 1; c <= 5 + 2 * W; c++) begin
            tick();
            if (c == 2 + W || c == 5 + 2 * W) begin
                total++;
                if (bus.m1_done !== 1'b1) begin
                    bad++; $display("FAIL hold_done c=%0d got=%b exp=1", c, bus.m1_done);
                end
            end
            if (c == 3 + W) begin
                total++;
                if (bus.m1_gnt !== 1'b0 || bus.s_rstrb !== 1'b0) begin
                    bad++; $display("FAIL hold_no_regrant got=%b/%b exp=0/0", bus.m1_gnt, bus.s_rstrb);
                end
            end
            if (c == 4 + W) begin
                total++;
                if (bus.m1_gnt !== 1'b1 || bus.s_rstrb !== 1'b1 || bus.s_addr !== 32'h800) begin
                    bad++; $display("FAIL hold_regrant got=%b/%b/%h exp=1/1/00000800", bus.m1_gnt, bus.s_rstrb, bus.s_addr);
                end
            end
        end
        bus.m1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b1;
        bus.m1_addr  = 32'h500;
        bus.m1_wdata = 32'hCAFE;
        bus.m1_wmask = 4'hF;
        tick();
        total++;
        if (bus.s_wmask !== 4'hF) begin
            bad++; $display("FAIL midrst_issue got=%b exp=1111", bus.s_wmask);
        end
        tick();
        total++;
        if (bus.m1_gnt !== 1'b1) begin
            bad++; $display("FAIL midrst_wait_gnt got=%b exp=1", bus.m1_gnt);
        end
        rst = 1'b1;
        #1;
        total++;
        if (outs() !== 137'd0) begin
            bad++; $display("FAIL midrst_outs got=%h exp=0", outs());
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (bus.m1_done !== 1'b0 || bus.m1_gnt !== 1'b0) begin
                bad++; $display("FAIL midrst_no_done c=%0d got=%b/%b exp=0/0", c, bus.m1_done, bus.m1_gnt);
            end
        end
        s_val        = 32'h99;
        bus.m0_addr  = 32'hA00;
        bus.m0_rstrb = 1'b1;
        for (int c = 1; c <= 3 + W; c++) begin
            tick();
            if (c == 1) bus.m0_rstrb = 1'b0;
            if (c == 2) begin
                total++;
                if (bus.s_rstrb !== 1'b1 || bus.s_addr !== 32'hA00) begin
                    bad++; $display("FAIL midrst_next_issue got=%b/%h exp=1/00000a00", bus.s_rstrb, bus.s_addr);
                end
            end
        end
        total++;
        if (bus.m0_rdata !== 32'h99 || bus.m0_rbusy !== 1'b0) begin
            bad++; $display("FAIL midrst_next_data got=%h/%b exp=00000099/0", bus.m0_rdata, bus.m0_rbusy);
        end
    endtask

    task automatic drive_m0(input int n_txn);
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        int          n;
        for (int i = 0; i < n_txn; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            m  = 4'($urandom_range(1, 15));
            bus.m0_addr  = a;
            bus.m0_wdata = d;
            bus.m0_rstrb = ~wr;
            bus.m0_wmask = wr ? m : 4'h0;
            if (wr) q0.push_back('{addr: a, data: d, mask: m});
            tick();
            bus.m0_rstrb = 1'b0;
            bus.m0_wmask = 4'h0;
            total++;
            if ((wr ? bus.m0_wbusy : bus.m0_rbusy) !== 1'b1) begin
                bad++; $display("FAIL rand_m0_busy txn=%0d got=0 exp=1", i);
            end
            n = 0;
            while ((bus.m0_rbusy || bus.m0_wbusy) && n < 60) begin tick(); n++; end
            total++;
            if (n >= 60) begin
                bad++; $display("FAIL rand_m0_timeout txn=%0d cycles=%0d", i, n);
            end
            if (!wr) begin
                total++;
                if (bus.m0_rdata !== rom(a)) begin
                    bad++; $display("FAIL rand_m0_rdata txn=%0d got=%h exp=%h", i, bus.m0_rdata, rom(a));
                end
            end
        end
        d0 = 1'b1;
    endtask

    task automatic drive_m1(input int n_txn);
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        int          n;
        for (int i = 0; i < n_txn; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            m  = 4'($urandom_range(1, 15));
            bus.m1_req   = 1'b1;
            bus.m1_we    = wr;
            bus.m1_addr  = a;
            bus.m1_wdata = d;
            bus.m1_wmask = m;
            if (wr) q1.push_back('{addr: a, data: d, mask: m});
            n = 0;
            do begin tick(); n++; end while (!bus.m1_done && n < 60);
            total++;
            if (!bus.m1_done) begin
                bad++; $display("FAIL rand_m1_timeout txn=%0d cycles=%0d", i, n);
            end
            if (!wr) begin
                total++;
                if (bus.m1_rdata !== rom(a)) begin
                    bad++; $display("FAIL rand_m1_rdata txn=%0d got=%h exp=%h", i, bus.m1_rdata, rom(a));
                end
            end
            bus.m1_req = 1'b0;
        end
        d1 = 1'b1;
    endtask

    task automatic watch_slave();
        wr_t obs;
        while (!(d0 && d1)) begin
            @(negedge clk);
            if (bus.s_wmask != 4'h0 || bus.s_rstrb) begin
                total++;
                if (bus.s_rstrb && bus.s_wmask != 4'h0) begin
                    bad++; $display("FAIL rand_strobe_clash got=%b/%b", bus.s_rstrb, bus.s_wmask);
                end
            end
            if (bus.s_wmask != 4'h0) begin
                obs = '{addr: bus.s_addr, data: bus.s_wdata, mask: bus.s_wmask};
                total++;
                if (q0.size() > 0 && q0[0] == obs) void'(q0.pop_front());
                else if (q1.size() > 0 && q1[0] == obs) void'(q1.pop_front());
                else begin
                    bad++; $display("FAIL rand_slave_write got=%h/%h/%b exp=pending write", obs.addr, obs.data, obs.mask);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        use_rom = 1'b1;
        q0.delete();
        q1.delete();
        d0 = 1'b0;
        d1 = 1'b0;
        fork
            drive_m0(30);
            drive_m1(30);
            watch_slave();
        join
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++; $display("FAIL rand_writes_missing got=%0d/%0d exp=0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_m0_write();
        test_m1_read();
        test_boundaries();
        test_contention();
        test_round_robin();
        test_m1_hold();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
